// File: rtl/regfile_onehot_wr.sv
// 32x32 RISC-V integer register file driven by a one-hot write strobe, with a sticky
// strobe-integrity flag and a saturating committed-write counter.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_onehot_wr #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WE,
  input  logic [31:0]      WE_ONEHOT,
  input  logic [XLEN-1:0]  WD,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [XLEN-1:0]  RD1,
  output logic [XLEN-1:0]  RD2,
  input  logic [4:0]       DBG_A,
  output logic [XLEN-1:0]  DBG_RD,
  output logic             ONEHOT_ERR,
  output logic [CNT_W-1:0] WR_COUNT
);

  // x0 is hardwired to zero, so only x1..x31 hold state.
  logic [XLEN-1:0]  regs_q [1:31];
  logic [XLEN-1:0]  regs_d [1:31];
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [5:0]       strobe_pop;
  logic             strobe_onehot;
  logic             wr_commit;
  logic             wr_illegal;
  logic [XLEN-1:0]  rd_view [0:31];

  // The decoder is not trusted: legality is a true population count of the strobe.
  always_comb begin
    strobe_pop = '0;
    for (int i = 0; i < 32; i++) begin
      strobe_pop = strobe_pop + 6'(WE_ONEHOT[i]);
    end
  end

  assign strobe_onehot = (strobe_pop == 6'd1);
  // A legal strobe selecting x0 is accepted but commits nothing.
  assign wr_commit     = WE & strobe_onehot & ~WE_ONEHOT[0];
  assign wr_illegal    = WE & ~strobe_onehot;

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_commit && WE_ONEHOT[i]) begin
        regs_d[i] = WD;
      end
    end
  end

  always_comb begin
    err_d = err_q | wr_illegal;
    cnt_d = cnt_q;
    if (wr_commit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rd_view[i] = regs_q[i];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (!RESET && wr_commit && WE_ONEHOT[i]) begin
        rd_view[i] = WD;
      end
`endif
    end
  end

  assign RD1        = rd_view[A1];
  assign RD2        = rd_view[A2];
  assign DBG_RD     = rd_view[DBG_A];
  assign ONEHOT_ERR = err_q;
  assign WR_COUNT   = cnt_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr: scoreboard of expected reads against a
// reference model, with a second CNT_W=2 instance for counter saturation.
module tb_regfile_onehot_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] oh;
  logic [31:0] wd;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  dbg_a;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] dbg_rd;
  logic        err;
  logic [15:0] cnt;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [31:0] dbg_s;
  logic        err_s;
  logic [1:0]  cnt_s;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_chk  = 0;
  int          n_fail = 0;

  logic [31:0] m_regs [0:31];
  logic        m_err;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt_s;

  always #5 clk = ~clk;

  regfile_onehot_wr #(.XLEN(32), .CNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .WE(we), .WE_ONEHOT(oh), .WD(wd),
    .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2), .DBG_A(dbg_a), .DBG_RD(dbg_rd),
    .ONEHOT_ERR(err), .WR_COUNT(cnt)
  );

  regfile_onehot_wr #(.XLEN(32), .CNT_W(2)) dut_sat (
    .CLK(clk), .RESET(rst), .WE(we), .WE_ONEHOT(oh), .WD(wd),
    .A1(a1), .A2(a2), .RD1(rd1_s), .RD2(rd2_s), .DBG_A(dbg_a), .DBG_RD(dbg_s),
    .ONEHOT_ERR(err_s), .WR_COUNT(cnt_s)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t x;
    x.tag = tag;
    x.val = v;
    sb_q.push_back(x);
  endtask

  // Expected combinational read of address a given the current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = m_regs[a];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!rst && we && ($countones(oh) == 1) && oh[a]) v = wd;
`endif
    return v;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [31:0] o,
                       input logic [31:0] d);
    rst = r;
    we  = w;
    oh  = o;
    wd  = d;
  endtask

  // Clock one edge, advance the model with the inputs presented at that edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_err   = 1'b0;
      m_cnt   = 16'h0;
      m_cnt_s = 2'h0;
    end else if (we) begin
      if ($countones(oh) != 1) begin
        m_err = 1'b1;
      end else if (!oh[0]) begin
        for (int i = 1; i < 32; i++) if (oh[i]) m_regs[i] = wd;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt_s != 2'h3) m_cnt_s = m_cnt_s + 2'd1;
      end
    end
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_status(input string tag);
    push({tag, "_err"}, {31'h0, m_err});
    push({tag, "_cnt"}, {16'h0, m_cnt});
    #1;
    e = sb_q.pop_front();
    n_chk++;
    if ({31'h0, err} !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.tag, err, e.val);
    end
    e = sb_q.pop_front();
    n_chk++;
    if ({16'h0, cnt} !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", e.tag, cnt, e.val);
    end
  endtask

  task automatic check_reads(input string tag, input logic [4:0] x1, input logic [4:0] x2,
                             input logic [4:0] xd);
    a1    = x1;
    a2    = x2;
    dbg_a = xd;
    push({tag, "_rd1"}, exp_read(x1));
    push({tag, "_rd2"}, exp_read(x2));
    push({tag, "_dbg"}, exp_read(xd));
    #1;
    e = sb_q.pop_front();
    n_chk++;
    if (rd1 !== e.val) begin
      n_fail++;
      $display("FAIL %s a=%0d: got %h want %h", e.tag, x1, rd1, e.val);
    end
    e = sb_q.pop_front();
    n_chk++;
    if (rd2 !== e.val) begin
      n_fail++;
      $display("FAIL %s a=%0d: got %h want %h", e.tag, x2, rd2, e.val);
    end
    e = sb_q.pop_front();
    n_chk++;
    if (dbg_rd !== e.val) begin
      n_fail++;
      $display("FAIL %s a=%0d: got %h want %h", e.tag, xd, dbg_rd, e.val);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    step();
    for (int a = 0; a < 32; a++) begin
      check_reads("reset", 5'(a), 5'(31 - a), 5'(a));
    end
    check_status("reset");
  endtask

  task automatic test_legal_writes();
    drive(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    step();
    check_reads("wr_x5", 5'd5, 5'd5, 5'd5);
    check_status("wr_x5");
    drive(1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678);
    step();
    check_reads("wr_x31", 5'd31, 5'd31, 5'd31);
    check_status("wr_x31");
  endtask

  task automatic test_x0_protect();
    drive(1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
    step();
    check_reads("x0", 5'd0, 5'd0, 5'd0);
    check_status("x0");
  endtask

  task automatic test_illegal();
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h4444_4444);
    step();
    drive(1'b0, 1'b1, 32'h0000_0030, 32'hAAAA_AAAA);
    check_reads("ill_multi_pre", 5'd4, 5'd5, 5'd5);
    step();
    check_reads("ill_multi", 5'd4, 5'd5, 5'd4);
    check_status("ill_multi");
    drive(1'b0, 1'b1, 32'h0000_0000, 32'h5555_5555);
    step();
    check_status("ill_zero");
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    step();
    check_status("ill_reset");
  endtask

  task automatic test_same_cycle();
    drive(1'b0, 1'b1, 32'h0000_0080, 32'h0000_00AB);
    check_reads("same_pre", 5'd7, 5'd7, 5'd7);
    step();
    check_reads("same_post", 5'd7, 5'd7, 5'd7);
    // Illegal strobe covering x7 must neither forward nor write.
    drive(1'b0, 1'b1, 32'h0000_0180, 32'h0000_00CD);
    check_reads("same_ill_pre", 5'd7, 5'd8, 5'd7);
    step();
    check_reads("same_ill_post", 5'd7, 5'd8, 5'd7);
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0033);
    step();
    drive(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0099);
    check_reads("rstpri_pre", 5'd3, 5'd3, 5'd3);
    step();
    check_reads("rstpri_post", 5'd3, 5'd0, 5'd3);
    check_status("rstpri");
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 32'h1 << i, 32'h100 + 32'(i));
      step();
      push($sformatf("sat_%0d", i), {30'h0, m_cnt_s});
      #1;
      e = sb_q.pop_front();
      n_chk++;
      if ({30'h0, cnt_s} !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", e.tag, cnt_s, e.val);
      end
    end
    check_status("sat_wide");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  idx;
    logic [31:0] strobe;
    for (int n = 0; n < 40; n++) begin
      idx    = 5'($urandom_range(0, 31));
      strobe = 32'h1 << idx;
      if ((n % 9) == 8) strobe = strobe | 32'h0000_4000;
      drive(1'b0, 1'b1, strobe, $urandom);
      check_reads("b2b", idx, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
    end
    check_status("b2b");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_err   = 1'b0;
    m_cnt   = 16'h0;
    m_cnt_s = 2'h0;
    a1      = 5'd0;
    a2      = 5'd0;
    dbg_a   = 5'd0;
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_legal_writes();
    test_x0_protect();
    test_illegal();
    test_same_cycle();
    test_reset_priority();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32x32 RISC-V integer register file, directly downstream of the 5-to-32 write-address decoder.
- Consumes the decoder's one-hot word as its per-register write strobe. Provides two combinational read ports for the datapath and one debug read port.
- Adds one-hot integrity checking with a sticky error flag and a saturating committed-write counter.

Parameters:
- XLEN, 32, register data width.
- CNT_W, 16, width of the committed-write counter.

Ports:
- CLK input 1: single clock; all state updates on rising edge.
- RESET input 1: synchronous, active-high reset.
- WE input 1: register write enable from the control unit.
- WE_ONEHOT input 32: one-hot register select from the decoder; bit i selects x(i).
- WD input XLEN: write data.
- A1 input 5: read address, port 1.
- A2 input 5: read address, port 2.
- RD1 output XLEN: read data, port 1.
- RD2 output XLEN: read data, port 2.
- DBG_A input 5: debug read address.
- DBG_RD output XLEN: debug read data.
- ONEHOT_ERR output 1: sticky flag; set on an illegal write strobe.
- WR_COUNT output CNT_W: count of committed writes, saturating.

Behaviour:
- Reset: RESET=1 at a rising edge clears x1..x31 to 0, ONEHOT_ERR to 0 and WR_COUNT to 0. Reset has priority over any write in the same cycle. A write presented together with RESET is discarded.
- x0: always reads 0. WE_ONEHOT[0] never modifies storage.
- Read ports:
  - RD1, RD2 and DBG_RD are combinational from the register array; zero-cycle latency.
  - Without bypass, reading a register in its write cycle returns the old value. The new value is visible after the edge.
- Write qualification is evaluated each rising edge with RESET=0:
  - WE=0: no write, no error check, counter unchanged.
  - WE=1 and exactly one bit set in WE_ONEHOT, bit i != 0: x(i) <= WD; WR_COUNT increments.
  - WE=1 and WE_ONEHOT == 32'h0000_0001 (x0): legal. No storage change, no count, no error.
  - WE=1 and WE_ONEHOT == 0, or more than one bit set: illegal. No register is written, ONEHOT_ERR <= 1, WR_COUNT unchanged.
- ONEHOT_ERR is sticky; only RESET clears it.
- WR_COUNT saturates at all-ones (2^CNT_W - 1); further committed writes leave it unchanged.
- One-hot detection: population count == 1, computed combinationally from WE_ONEHOT. No assumption about decoder correctness.
- Storage: no state other than x1..x31, ONEHOT_ERR and WR_COUNT.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: same-cycle forwarding. If the current cycle holds a legal committed write to x(i), i != 0, then any read port (RD1, RD2, DBG_RD) addressing i returns WD combinationally in that cycle.
  - No forwarding when RESET=1, when the write is illegal, or when the target is x0. In those cases x0 still reads 0.
- Not defined: pure array reads; the new value is visible only after the edge.

Test Plan:
- Reset then read: pulse RESET one cycle, sweep A1/A2/DBG_A over 0..31 -> all reads 0, ONEHOT_ERR=0, WR_COUNT=0.
- Legal writes: WE=1, WE_ONEHOT=32'h0000_0020, WD=32'hDEAD_BEEF, one edge -> x5 reads 32'hDEAD_BEEF on all ports, WR_COUNT=1. Repeat for x31 with WE_ONEHOT=32'h8000_0000, WD=32'h1234_5678 -> WR_COUNT=2.
- x0 protection: WE=1, WE_ONEHOT=32'h0000_0001, WD=32'hFFFF_FFFF -> RD1 at A1=0 reads 0, WR_COUNT unchanged, ONEHOT_ERR=0.
- Illegal strobes:
  - WE=1, WE_ONEHOT=32'h0000_0030, WD=32'hAAAA_AAAA -> x4 and x5 keep their prior values, ONEHOT_ERR=1 persists.
  - Then WE_ONEHOT=0 -> still 1, no count change.
  - RESET -> ONEHOT_ERR=0.
- Write/read same cycle: A1=7, write x7 with WD=32'h0000_00AB over a prior value of 0 -> RD1=0 before the edge and 32'h0000_00AB after. With REGFILE_WRITE_BYPASS_EN defined -> RD1=32'h0000_00AB before the edge.
- Reset mid-operation and saturation:
  - RESET=1 with a legal write to x3 -> x3=0, WR_COUNT=0.
  - With CNT_W=2, four legal writes -> WR_COUNT=3, and stays 3.
